// File: rtl/clock_display_scan_if.sv
// Time-of-day bus from the clock counter to the display scanner:
// binary sec/min/hour plus the display enable and scan-rate setting.
interface clock_display_scan_if #(
  parameter int P_DIV_BIT  = 20,
  parameter int P_SEC_BIT  = 6,
  parameter int P_MIN_BIT  = 6,
  parameter int P_HOUR_BIT = 5
);
  logic                  en;
  logic [P_DIV_BIT-1:0]  i_scan_div;
  logic [P_SEC_BIT-1:0]  sec;
  logic [P_MIN_BIT-1:0]  min;
  logic [P_HOUR_BIT-1:0] hour;

  modport master (
    output en,
    output i_scan_div,
    output sec,
    output min,
    output hour
  );

  modport slave (
    input en,
    input i_scan_div,
    input sec,
    input min,
    input hour
  );
endinterface

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed hh.mm.ss display driver: snapshots the time once per
// frame, converts to BCD and scans a common-anode 7-segment display.
module clock_display_scan #(
  parameter int P_DIV_BIT  = 20,
  parameter int P_SEC_BIT  = 6,
  parameter int P_MIN_BIT  = 6,
  parameter int P_HOUR_BIT = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  clock_display_scan_if.slave   bus,
  output logic [6:0]            seg,
  output logic [5:0]            an,
  output logic                  dp
);

  localparam logic [6:0] C_SEG_BLANK = 7'h7F;
  localparam logic [5:0] C_AN_OFF    = 6'h3F;
  localparam logic [2:0] C_IDX_LAST  = 3'd5;

  logic [P_DIV_BIT-1:0]  prescale_r;
  logic [P_DIV_BIT-1:0]  last_count_s;
  logic                  tick_s;
  logic [2:0]            idx_r;
  logic                  frame_end_s;

  logic [P_SEC_BIT-1:0]  shadow_sec_r;
  logic [P_MIN_BIT-1:0]  shadow_min_r;
  logic [P_HOUR_BIT-1:0] shadow_hour_r;

  logic [7:0]            sec_bcd_s;
  logic [7:0]            min_bcd_s;
  logic [7:0]            hour_bcd_s;
  logic [3:0]            digit_s;
  logic                  blank_s;
  logic [5:0]            an_s;
  logic                  dp_s;

  // Binary (0..159) to two BCD digits {tens, ones}.
  function automatic logic [7:0] to_bcd(input logic [7:0] v);
    logic [7:0] q;
    logic [7:0] r;
    q = v / 8'd10;
    r = v % 8'd10;
    return {q[3:0], r[3:0]};
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = C_SEG_BLANK;
    endcase
    return s;
  endfunction

  // Slot length decode; >= comparison makes a shrinking divider wrap at once.
  always_comb begin
    last_count_s = '0;
    if (bus.i_scan_div < P_DIV_BIT'(2)) begin
      last_count_s = '0;
    end else begin
      last_count_s = bus.i_scan_div - P_DIV_BIT'(1);
    end
    tick_s      = (prescale_r >= last_count_s);
    frame_end_s = tick_s && (idx_r == C_IDX_LAST);
  end

  // Prescaler and digit index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prescale_r <= '0;
      idx_r      <= 3'd0;
    end else if (!bus.en) begin
      prescale_r <= '0;
      idx_r      <= 3'd0;
    end else if (tick_s) begin
      prescale_r <= '0;
      idx_r      <= (idx_r == C_IDX_LAST) ? 3'd0 : idx_r + 3'd1;
    end else begin
      prescale_r <= prescale_r + P_DIV_BIT'(1);
      idx_r      <= idx_r;
    end
  end

  // Shadow snapshot: tracks inputs while blanked, otherwise only at frame end.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_sec_r  <= '0;
      shadow_min_r  <= '0;
      shadow_hour_r <= '0;
    end else if (!bus.en || frame_end_s) begin
      shadow_sec_r  <= bus.sec;
      shadow_min_r  <= bus.min;
      shadow_hour_r <= bus.hour;
    end else begin
      shadow_sec_r  <= shadow_sec_r;
      shadow_min_r  <= shadow_min_r;
      shadow_hour_r <= shadow_hour_r;
    end
  end

  // BCD conversion of the snapshot and selection of the current digit.
  always_comb begin
    sec_bcd_s  = to_bcd(8'(shadow_sec_r));
    min_bcd_s  = to_bcd(8'(shadow_min_r));
    hour_bcd_s = to_bcd(8'(shadow_hour_r));
    digit_s    = 4'd0;
    blank_s    = 1'b0;
    case (idx_r)
      3'd0:    digit_s = sec_bcd_s[3:0];
      3'd1:    digit_s = sec_bcd_s[7:4];
      3'd2:    digit_s = min_bcd_s[3:0];
      3'd3:    digit_s = min_bcd_s[7:4];
      3'd4:    digit_s = hour_bcd_s[3:0];
      3'd5: begin
        digit_s = hour_bcd_s[7:4];
        blank_s = (hour_bcd_s[7:4] == 4'd0);
      end
      default: begin
        digit_s = 4'd0;
        blank_s = 1'b1;
      end
    endcase
    an_s = ~(6'b000001 << idx_r);
    dp_s = ~((idx_r == 3'd2) || (idx_r == 3'd4));
  end

  // Registered display pins, blank in reset or while disabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg <= C_SEG_BLANK;
      an  <= C_AN_OFF;
      dp  <= 1'b1;
    end else if (!bus.en) begin
      seg <= C_SEG_BLANK;
      an  <= C_AN_OFF;
      dp  <= 1'b1;
    end else begin
      seg <= blank_s ? C_SEG_BLANK : seg_decode(digit_s);
      an  <= an_s;
      dp  <= dp_s;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan with a frame-arithmetic reference
// model checked every cycle plus hand-computed literal expectations.
module tb_clock_display_scan;
  logic       clk;
  logic       reset;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;

  int n_checks = 0;
  int n_fail   = 0;
  int ecnt     = 0;

  localparam int H = 4096;
  bit h_rst [0:H-1];
  bit h_en  [0:H-1];
  int h_div [0:H-1];
  int h_sec [0:H-1];
  int h_min [0:H-1];
  int h_hour[0:H-1];

  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  clock_display_scan_if bus_if ();

  clock_display_scan dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave),
    .seg   (seg),
    .an    (an),
    .dp    (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record what the DUT sampled at each rising edge.
  always @(posedge clk) begin
    if (ecnt < H) begin
      h_rst[ecnt]  <= reset;
      h_en[ecnt]   <= bus_if.en;
      h_div[ecnt]  <= int'(bus_if.i_scan_div);
      h_sec[ecnt]  <= int'(bus_if.sec);
      h_min[ecnt]  <= int'(bus_if.min);
      h_hour[ecnt] <= int'(bus_if.hour);
    end
    ecnt <= ecnt + 1;
  end

  // Expected {seg, an, dp} after edge k: position in the run since the last
  // reset/disable edge gives digit and frame; frame f shows inputs of edge j+6Nf.
  function automatic logic [13:0] model(int k);
    int j, n, m, f, d, e, v, dig;
    logic [6:0] s;
    j = -1;
    for (int i = k; i >= 0; i--) begin
      if (!h_rst[i] || !h_en[i]) begin
        j = i;
        break;
      end
    end
    if (j == k || j < 0) return {7'h7F, 6'h3F, 1'b1};
    n = (h_div[k] < 2) ? 1 : h_div[k];
    m = k - j - 1;
    f = m / (6 * n);
    d = (m / n) % 6;
    e = j + 6 * n * f;
    if (!h_rst[e]) v = 0;
    else if (d < 2) v = h_sec[e];
    else if (d < 4) v = h_min[e];
    else v = h_hour[e];
    dig = (d % 2 == 0) ? (v % 10) : (v / 10);
    s = seg_tab[dig];
    if (d == 5 && dig == 0) s = 7'h7F;
    return {s, 6'h3F ^ (6'd1 << d), (d == 2 || d == 4) ? 1'b0 : 1'b1};
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin : cmp
    logic [13:0] exp_v;
    if (ecnt > 0 && ecnt <= H) begin
      exp_v = model(ecnt - 1);
      n_checks++;
      if ({seg, an, dp} !== exp_v) begin
        n_fail++;
        $display("FAIL model cyc=%0d got seg=%h an=%h dp=%b exp seg=%h an=%h dp=%b",
                 ecnt - 1, seg, an, dp, exp_v[13:7], exp_v[6:1], exp_v[0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [6:0] es, input logic [5:0] ea,
                     input logic ed);
    n_checks++;
    if (seg !== es || an !== ea || dp !== ed) begin
      n_fail++;
      $display("FAIL %s got seg=%h an=%h dp=%b exp seg=%h an=%h dp=%b",
               name, seg, an, dp, es, ea, ed);
    end
  endtask

  task automatic chk_an(input string name, input logic [5:0] ea);
    n_checks++;
    if (an !== ea) begin
      n_fail++;
      $display("FAIL %s got an=%h exp an=%h", name, an, ea);
    end
  endtask

  logic [6:0] t2_seg [0:5] = '{7'h78, 7'h30, 7'h12, 7'h40, 7'h10, 7'h7F};
  logic [5:0] t_an   [0:5] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
  logic       t2_dp  [0:5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [6:0] t6_seg [0:5] = '{7'h10, 7'h12, 7'h10, 7'h12, 7'h30, 7'h24};

  initial begin
    reset = 1'b0;
    bus_if.en = 1'b1;
    bus_if.i_scan_div = 20'd4;
    bus_if.sec = 6'd59;
    bus_if.min = 6'd0;
    bus_if.hour = 5'd0;

    // 1: reset held, then digit 0 of 00:00:00
    step(3);
    chk("reset_hold", 7'h7F, 6'h3F, 1'b1);
    reset = 1'b1;
    step(1);
    chk("reset_release", 7'h40, 6'h3E, 1'b1);

    // 2: 09:05:37 at 4 clocks per digit
    bus_if.en = 1'b0;
    bus_if.hour = 5'd9;
    bus_if.min = 6'd5;
    bus_if.sec = 6'd37;
    step(2);
    chk("en_low_blank", 7'h7F, 6'h3F, 1'b1);
    bus_if.en = 1'b1;
    step(1);
    for (int d = 0; d < 6; d++) begin
      chk($sformatf("frame_digit%0d", d), t2_seg[d], t_an[d], t2_dp[d]);
      step(4);
    end
    chk("frame_repeat", 7'h78, 6'h3E, 1'b1);

    // 3: mid-frame sec change appears only next frame
    step(4);
    chk("mid_frame_hold", 7'h30, 6'h3D, 1'b1);
    bus_if.sec = 6'd12;
    step(20);
    chk("next_frame_ones", 7'h24, 6'h3E, 1'b1);
    step(4);
    chk("next_frame_tens", 7'h79, 6'h3D, 1'b1);

    // 5: drop enable at digit 3, re-enable with new seconds
    step(8);
    chk("at_digit3", 7'h40, 6'h37, 1'b1);
    bus_if.en = 1'b0;
    bus_if.sec = 6'd44;
    step(1);
    chk("en_drop", 7'h7F, 6'h3F, 1'b1);
    bus_if.en = 1'b1;
    step(1);
    chk("en_restart", 7'h19, 6'h3E, 1'b1);

    // 4: one clock per digit with div 0 then 1
    bus_if.en = 1'b0;
    bus_if.i_scan_div = 20'd0;
    step(1);
    bus_if.en = 1'b1;
    step(1);
    chk_an("div0_a", 6'h3E);
    step(1);
    chk_an("div0_b", 6'h3D);
    bus_if.i_scan_div = 20'd1;
    for (int i = 2; i < 8; i++) begin
      step(1);
      chk_an($sformatf("div1_%0d", i), t_an[i % 6]);
    end

    // 6: 23:59:59 at div 2, then 00:00:00 with blanked hour tens
    bus_if.en = 1'b0;
    bus_if.i_scan_div = 20'd2;
    bus_if.hour = 5'd23;
    bus_if.min = 6'd59;
    bus_if.sec = 6'd59;
    step(1);
    bus_if.en = 1'b1;
    step(1);
    for (int d = 0; d < 6; d++) begin
      chk($sformatf("max_digit%0d", d), t6_seg[d], t_an[d], t2_dp[d]);
      step(2);
    end
    bus_if.hour = 5'd0;
    bus_if.min = 6'd0;
    bus_if.sec = 6'd0;
    step(12);
    chk("zero_digit0", 7'h40, 6'h3E, 1'b1);
    step(10);
    chk("zero_blank5", 7'h7F, 6'h1F, 1'b1);

    // Out-of-range values and reset mid-frame
    bus_if.en = 1'b0;
    bus_if.sec = 6'd63;
    bus_if.hour = 5'd31;
    step(1);
    bus_if.en = 1'b1;
    step(3);
    chk("oor_sec_tens", 7'h02, 6'h3D, 1'b1);
    step(8);
    chk("oor_hour_tens", 7'h30, 6'h1F, 1'b1);
    reset = 1'b0;
    step(1);
    chk("reset_mid", 7'h7F, 6'h3F, 1'b1);
    reset = 1'b1;
    step(1);
    chk("reset_mid_release", 7'h40, 6'h3E, 1'b1);
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
- Reader side of the time-of-day counter's sec/min/hour bus.
- Snapshots the binary sec/min/hour values once per display frame and converts each to two BCD digits.
- Time-multiplexes the six digits onto a common-anode 7-segment display: active-low segments and anodes.
- Sits between the clock counter outputs and the board display pins.

Parameters:
- P_DIV_BIT, 20, width of i_scan_div (clocks-per-digit-slot).
- P_SEC_BIT, 6, width of sec input.
- P_MIN_BIT, 6, width of min input.
- P_HOUR_BIT, 5, width of hour input.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-low reset.
- en  input  1  display enable; low blanks display and clears the scan.
- i_scan_div  input  P_DIV_BIT  digit slot length in clocks; 0 and 1 both mean 1.
- sec  input  P_SEC_BIT  binary seconds.
- min  input  P_MIN_BIT  binary minutes.
- hour  input  P_HOUR_BIT  binary hours.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  6  digit anodes, active-low one-hot; an[0] = rightmost digit.
- dp  output  1  decimal point, active-low.

Behaviour:
- Interface: one clock (clk); reset is synchronous, active-low, sampled on the rising edge of clk.
- Reset (reset=0 at a rising edge):
  - prescaler=0, digit index idx=0.
  - shadow_sec, shadow_min, shadow_hour = 0.
  - an=6'h3F, seg=7'h7F, dp=1.
- Slot length: N = (i_scan_div<2) ? 1 : i_scan_div.
- Prescaler:
  - Counts 0..N-1; tick is asserted in the cycle where prescaler==N-1.
  - On tick the prescaler returns to 0.
  - If i_scan_div drops below the current count, the prescaler wraps on the next cycle.
- idx:
  - Advances 0→1→…→5→0 on tick.
  - Digit order: 0 sec ones, 1 sec tens, 2 min ones, 3 min tens, 4 hour ones, 5 hour tens.
- Shadow load:
  - shadow_* <= inputs every cycle while en=0.
  - shadow_* <= inputs on the cycle where tick && idx==5 (frame boundary).
  - Otherwise shadows hold. Input changes mid-frame never alter the frame being shown.
- Conversion:
  - tens = v/10, ones = v%10, computed on the shadow values.
  - Out-of-range inputs (sec/min up to 63, hour up to 31) display their arithmetic digits. No clamping.
- Segment codes (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
- Leading blank: digit 5 with hour tens==0 drives seg=7'h7F, while its anode is still driven.
- dp=0 on idx 2 and 4 (hh.mm.ss separators); dp=1 otherwise.
- Output registers (seg, an, dp):
  - Updated every cycle from the current idx/shadows/en, giving one-cycle latency from an idx change.
  - an = ~(6'b1 << idx) when en=1.
- en=0:
  - Prescaler and idx cleared to 0.
  - Next cycle an=6'h3F, seg=7'h7F, dp=1.
  - On en rising, digit 0 of the freshly tracked values appears one cycle later and is held N clocks.
- Reset mid-frame: immediate return to reset state at that edge, regardless of en.

Test Plan:
1. Reset held low 3 cycles with en=1, sec=59 → an=3F, seg=7F, dp=1 throughout. One cycle after release, digit 0 of 00:00:00 is shown (seg=40, an=3E).
2. en=0, i_scan_div=4, hour=9, min=5, sec=37; then en=1 → each digit held 4 clocks:
   - seg/an/dp = 78/3E/1, 30/3D/1, 12/3B/0, 40/37/1, 10/2F/0, 7F/1F/1, then repeat.
3. Same as 2, but change sec to 12 during idx=1 → current frame still shows 7,3. The next frame shows 2 (seg=24), 1 (seg=79).
4. i_scan_div=0, then 1 → an rotates every clock: 3E,3D,3B,37,2F,1F,3E…
5. Drop en during idx=3 → next cycle an=3F/seg=7F. Re-raise en → sequence restarts at an=3E with the latest sec value.
6. hour=23, min=59, sec=59, div=2 → digits 9,5,9,5,3,2 (seg 10,12,10,12,30,24). Change to 0/0/0 → next frame digit 5 is blank (7F) and the others show 40.
